// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared state and opcode types for the RAM burst controller
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_skid_buf.sv
// rtl/mem_skid_buf.sv - 2-entry FIFO that parks RAM read data while the read stream is stalled
module mem_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] e0_q;
    logic [DATA_WIDTH-1:0] e1_q;
    logic [1:0]            count_q;

    assign count_o = count_q;
    assign head_o  = e0_q;

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= push_data_i;
                    else                 e1_q <= push_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    e0_q    <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_q <= push_data_i;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - turns one burst command into consecutive single-port RAM accesses
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  inflight_q;

    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [1:0]            occupancy;
    logic                  wr_beat;
    logic                  rd_issue;
    logic                  rd_last;
    logic                  pop;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign s_ready   = (state_q == WR) && (rem_q != '0);
    assign wr_beat   = s_valid && s_ready;
    assign mem_we    = wr_beat;
    assign mem_wdata = s_data;
    assign mem_addr  = addr_q;
    assign m_valid   = (buf_count != 2'd0);
    assign m_data    = buf_head;
    assign pop       = m_valid && m_ready;

    // Slots that will be taken next cycle if nothing new is issued; a read is only
    // issued when its data is guaranteed a place in the buffer.
    assign occupancy = buf_count + {1'b0, inflight_q} - {1'b0, pop};
    assign rd_issue  = (state_q == RD) && (rem_q != '0) && (occupancy < 2'd2);
    assign rd_last   = (rem_q == '0) && !inflight_q &&
                       ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

    mem_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_data_i(mem_rdata),
        .pop_i      (pop),
        .count_o    (buf_count),
        .head_o     (buf_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        rem_q  <= len;
                        if (len == '0)                  state_q <= FIN;
                        else if (op_e'(op) == OP_WRITE) state_q <= WR;
                        else                            state_q <= RD;
                    end
                end
                WR: begin
                    if (wr_beat) begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == LEN_WIDTH'(1)) state_q <= FIN;
                    end
                end
                RD: begin
                    inflight_q <= rd_issue;
                    if (rd_issue) begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                    end
                    if (rd_last) state_q <= FIN;
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - table-driven scoreboard bench for mem_burst_ctrl with a RAM model
module tb_mem_burst_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LW = 5;
    localparam int NV = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          op;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:15];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic op;
        int   base;
        int   ln;
        int   mode;
    } vec_t;

    vec_t          tbl [NV];
    int            pat [6] = '{1, 0, 0, 1, 0, 1};
    logic [DW-1:0] shadow [0:15];
    logic [11:0]   wq [$];
    logic [DW-1:0] rq [$];

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            dones, first_valid, first_pop, first_we, last_act, done_cyc;
    bit            done_seen, beat, prev_stall;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sample();
        logic [11:0]   w;
        logic [DW-1:0] r;
        if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
        end
        prev_stall = rst_n && m_valid && !m_ready;
        prev_data  = m_data;
        beat = s_valid && s_ready;
        if (mem_we) begin
            if (wq.size() == 0) check("unexpected_write", 1, 0);
            else begin
                w = wq.pop_front();
                check("wr_addr", mem_addr, w[11:8]);
                check("wr_data", mem_wdata, w[7:0]);
            end
            if (first_we < 0) first_we = cyc;
            last_act = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            if (rq.size() == 0) check("unexpected_read_beat", 1, 0);
            else begin
                r = rq.pop_front();
                check("rd_data", m_data, r);
            end
            if (first_pop < 0) first_pop = cyc;
            last_act = cyc;
        end
        if (done) begin
            dones++;
            done_seen = 1'b1;
            done_cyc  = cyc;
            check("busy_during_done", busy, 1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_burst(input int k, input logic op_v, input int base, input int ln, input int mode);
        logic [DW-1:0] wdata [0:31];
        int idx, t, acc_cyc, a;
        for (int i = 0; i < ln; i++) begin
            a = (base + i) % 16;
            if (op_v) begin
                wdata[i]  = 8'(11 * (i + 1) + 37 * k);
                shadow[a] = wdata[i];
                wq.push_back({4'(a), wdata[i]});
            end else begin
                rq.push_back(shadow[a]);
            end
        end
        dones = 0; done_seen = 1'b0; first_valid = -1; first_pop = -1;
        first_we = -1; last_act = -1; done_cyc = -1;
        op = op_v; base_addr = 4'(base); len = 5'(ln); start = 1'b1;
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        acc_cyc = cyc;
        start = 1'b0;
        idx = 0;
        t = 0;
        while (!done_seen && t < 300) begin
            s_valid = op_v && (idx < ln) && (mode != 2 || $urandom_range(0, 1) == 1);
            s_data  = (op_v && idx < ln) ? wdata[idx] : '0;
            case (mode)
                1:       m_ready = (pat[t % 6] == 1);
                2:       m_ready = ($urandom_range(0, 1) == 1);
                default: m_ready = 1'b1;
            endcase
            start = (mode == 3 && t == 2);
            if (start) begin
                op = 1'b1; base_addr = 4'd0; len = 5'd3;
            end
            tick();
            if (beat) idx++;
            t++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        check("burst_timeout", done_seen, 1);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("done_count", dones, 1);
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        wq.delete();
        rq.delete();
        if (ln == 0) begin
            check("empty_done_latency", done_cyc, acc_cyc);
            check("empty_no_m_valid", first_valid, -1);
            check("empty_no_mem_we", first_we, -1);
        end else begin
            check("done_after_last_beat", done_cyc, last_act + 1);
        end
        if (mode == 0 && ln > 0) begin
            if (!op_v) begin
                check("rd_first_valid_latency", first_valid, acc_cyc + 2);
                check("rd_back_to_back", last_act - first_pop, ln - 1);
            end else begin
                check("wr_first_beat", first_we, acc_cyc);
                check("wr_back_to_back", last_act - first_we, ln - 1);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2, 4, 0};
        tbl[1]  = '{1'b0, 2, 4, 0};
        tbl[2]  = '{1'b1, 6, 6, 2};
        tbl[3]  = '{1'b0, 6, 6, 1};
        tbl[4]  = '{1'b1, 14, 4, 0};
        tbl[5]  = '{1'b0, 14, 4, 0};
        tbl[6]  = '{1'b0, 0, 0, 0};
        tbl[7]  = '{1'b1, 5, 0, 0};
        tbl[8]  = '{1'b0, 2, 4, 3};
        tbl[9]  = '{1'b1, 9, 20, 2};
        tbl[10] = '{1'b0, 9, 20, 2};

        rst_n = 1'b0; start = 1'b0; op = 1'b0; base_addr = '0; len = '0;
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        prev_stall = 1'b0; prev_data = '0; beat = 1'b0; done_seen = 1'b0;
        dones = 0; first_valid = -1; first_pop = -1; first_we = -1; last_act = -1; done_cyc = -1;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_m_data", m_data, 0);
        rst_n = 1'b1;
        s_valid = 1'b0;

        for (int k = 0; k < NV; k++) begin
            do_burst(k, tbl[k].op, tbl[k].base, tbl[k].ln, tbl[k].mode);
        end

        // Abort a read burst with a full buffer, then prove the controller recovers.
        dones = 0;
        op = 1'b0; base_addr = 4'd2; len = 5'd8; start = 1'b1; m_ready = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_buffer_valid", m_valid, 1);
        rst_n = 1'b0;
        tick();
        check("abort_m_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("abort_no_done", dones, 0);
        check("abort_idle_m_valid", m_valid, 0);

        do_burst(20, 1'b0, 2, 4, 2);
        do_burst(21, 1'b0, 14, 4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
